// File: rtl/fsm_count_pkg.sv
// Shared types and sequence constants for the counter checker.
package fsm_count_pkg;

  // Checker state, encoded to match the state output.
  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Legal values of the counter under check, in sequence order.
  localparam logic [7:0] C0  = 8'd0;
  localparam logic [7:0] C7  = 8'd7;
  localparam logic [7:0] C1  = 8'd1;
  localparam logic [7:0] C3  = 8'd3;
  localparam logic [7:0] C2  = 8'd2;
  localparam logic [7:0] C5  = 8'd5;
  localparam logic [7:0] C11 = 8'd11;
  localparam logic [7:0] C13 = 8'd13;

endpackage

// File: rtl/fsm_count_ref_model.sv
// Golden next-value function of the counter under check.
import fsm_count_pkg::*;

module fsm_count_ref_model (
  input  logic [7:0] c,
  input  logic       st,
  input  logic       sk,
  output logic [7:0] next
);

  // Next counter value from current value, start and skip.
  always_comb begin
    next = C0;
    case (c)
      C0:      next = st ? C7 : C0;
      C7:      next = sk ? C3 : C1;
      C1:      next = sk ? C2 : C3;
      C3:      next = sk ? C5 : C2;
      C2:      next = sk ? C11 : C5;
      C5:      next = sk ? C13 : C11;
      C11:     next = C13;
      C13:     next = C7;
      default: next = C0;
    endcase
  end

endmodule

// File: rtl/fsm_count_checker.sv
// Checks a sequence counter cycle by cycle against the golden model,
// counting mismatches and completed laps (13 -> 7).
import fsm_count_pkg::*;

module fsm_count_checker #(
  parameter int ERR_W    = 8,
  parameter int FAULT_TH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             skip,
  input  logic [7:0]       count_in,
  input  logic             skip_to_five_in,
  input  logic             check_en,
  input  logic             clear,
  output logic             err_seq,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_cnt,
  output logic             lap_done,
  output logic [15:0]      lap_cnt,
  output logic [1:0]       state
);

  localparam int CW = $clog2(FAULT_TH + 1);
  localparam logic [CW-1:0]    TH      = CW'(FAULT_TH);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state_q, state_d;
  logic [7:0]       prev_count;
  logic             prev_start, prev_skip;
  logic [CW-1:0]    consec_q, consec_d, consec_inc;
  logic             err_seq_d, err_flag_d, lap_done_d;
  logic [ERR_W-1:0] err_cnt_d;
  logic [15:0]      lap_cnt_d;
  logic [7:0]       exp_count;
  logic             exp_s2f, mismatch;

  fsm_count_ref_model u_ref (
    .c    (prev_count),
    .st   (prev_start),
    .sk   (prev_skip),
    .next (exp_count)
  );

  // Expected flag uses same-edge samples; at most one mismatch per cycle.
  always_comb begin
    exp_s2f    = (count_in == C3) && skip;
    mismatch   = (count_in != exp_count) || (skip_to_five_in != exp_s2f);
    consec_inc = consec_q + CW'(1);
  end

  // Next state, counters and output pulses; clear overrides increments.
  always_comb begin
    state_d    = state_q;
    consec_d   = consec_q;
    err_seq_d  = 1'b0;
    lap_done_d = 1'b0;
    err_flag_d = err_flag;
    err_cnt_d  = err_cnt;
    lap_cnt_d  = lap_cnt;
    if (!check_en) begin
      state_d = SYNC;
    end else begin
      case (state_q)
        SYNC: begin
          if (count_in == C0) begin
            state_d  = TRACK;
            consec_d = '0;
          end
        end
        TRACK: begin
          if (mismatch) begin
            err_seq_d  = 1'b1;
            err_flag_d = 1'b1;
            if (err_cnt != ERR_MAX) err_cnt_d = err_cnt + ERR_W'(1);
            consec_d = consec_inc;
            if (consec_inc >= TH) state_d = FAULT;
          end else begin
            consec_d = '0;
            if (prev_count == C13 && count_in == C7) begin
              lap_done_d = 1'b1;
              lap_cnt_d  = lap_cnt + 16'd1;
            end
          end
        end
        FAULT: begin
          if (count_in == C0) begin
            state_d  = TRACK;
            consec_d = '0;
          end
        end
        default: state_d = SYNC;
      endcase
    end
    if (clear) begin
      err_cnt_d  = '0;
      lap_cnt_d  = '0;
      err_flag_d = 1'b0;
    end
  end

  // History and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= SYNC;
      consec_q   <= '0;
      prev_count <= '0;
      prev_start <= 1'b0;
      prev_skip  <= 1'b0;
      err_seq    <= 1'b0;
      err_flag   <= 1'b0;
      err_cnt    <= '0;
      lap_done   <= 1'b0;
      lap_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      consec_q   <= consec_d;
      prev_count <= count_in;
      prev_start <= start;
      prev_skip  <= skip;
      err_seq    <= err_seq_d;
      err_flag   <= err_flag_d;
      err_cnt    <= err_cnt_d;
      lap_done   <= lap_done_d;
      lap_cnt    <= lap_cnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_fsm_count_checker.sv
// Directed bench for fsm_count_checker with hand-computed expectations.
module tb_fsm_count_checker;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        skip = 1'b0;
  logic [7:0]  count_in = 8'd0;
  logic        skip_to_five_in = 1'b0;
  logic        check_en = 1'b0;
  logic        clear = 1'b0;
  logic        err_seq, err_flag, lap_done;
  logic [7:0]  err_cnt;
  logic [15:0] lap_cnt;
  logic [1:0]  state;

  logic [7:0]  ref_c = 8'd0;
  logic        ref_st = 1'b0, ref_sk = 1'b0;
  logic [7:0]  ref_next;

  int n_checks = 0;
  int n_fail = 0;
  int seen_err = 0;
  int seen_lap = 0;

  fsm_count_checker #(.ERR_W(8), .FAULT_TH(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .skip(skip),
    .count_in(count_in), .skip_to_five_in(skip_to_five_in),
    .check_en(check_en), .clear(clear), .err_seq(err_seq),
    .err_flag(err_flag), .err_cnt(err_cnt), .lap_done(lap_done),
    .lap_cnt(lap_cnt), .state(state)
  );

  fsm_count_ref_model u_ref_chk (
    .c(ref_c), .st(ref_st), .sk(ref_sk), .next(ref_next)
  );

  // Clock
  always #5 clk = ~clk;

  // Drive one value for one edge, then sample 1 ns after that edge.
  task automatic drive(input logic [7:0] c, input logic s2f);
    count_in = c;
    skip_to_five_in = s2f;
    @(posedge clk);
    #1;
    if (err_seq) seen_err++;
    if (lap_done) seen_lap++;
  endtask

  // Drop to SYNC for one cycle so a new sequence starts from fresh history.
  task automatic resync();
    check_en = 1'b0;
    drive(8'd0, 1'b0);
    check_en = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_checks++;
    if ({err_seq, err_flag, lap_done} !== 3'b000 || err_cnt !== 8'd0 || lap_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_outputs got seq=%0b flag=%0b lap=%0b ec=%0d lc=%0d exp all 0", err_seq, err_flag, lap_done, err_cnt, lap_cnt);
    end
    rstn = 1'b1;
  endtask

  task automatic test_ref_model();
    logic [7:0] vc  [16] = '{8'd0, 8'd0, 8'd7, 8'd7, 8'd1, 8'd1, 8'd3, 8'd3, 8'd2, 8'd2, 8'd5, 8'd5, 8'd11, 8'd13, 8'd4, 8'd255};
    logic       vst [16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       vsk [16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] vn  [16] = '{8'd7, 8'd0, 8'd3, 8'd1, 8'd2, 8'd3, 8'd5, 8'd2, 8'd11, 8'd5, 8'd13, 8'd11, 8'd13, 8'd7, 8'd0, 8'd0};
    for (int i = 0; i < 16; i++) begin
      ref_c = vc[i]; ref_st = vst[i]; ref_sk = vsk[i];
      #1;
      n_checks++;
      if (ref_next !== vn[i]) begin
        n_fail++; $display("FAIL ref_model c=%0d st=%0b sk=%0b got=%0d exp=%0d", vc[i], vst[i], vsk[i], ref_next, vn[i]);
      end
    end
  endtask

  task automatic test_lap();
    logic [7:0] seq [9] = '{8'd0, 8'd7, 8'd1, 8'd3, 8'd2, 8'd5, 8'd11, 8'd13, 8'd7};
    check_en = 1'b1; start = 1'b1; skip = 1'b0;
    seen_err = 0; seen_lap = 0;
    for (int i = 0; i < 9; i++) drive(seq[i], 1'b0);
    n_checks++;
    if (seen_err !== 0) begin n_fail++; $display("FAIL lap_err_seq got=%0d exp=0", seen_err); end
    n_checks++;
    if (seen_lap !== 1) begin n_fail++; $display("FAIL lap_pulses got=%0d exp=1", seen_lap); end
    n_checks++;
    if (lap_cnt !== 16'd1) begin n_fail++; $display("FAIL lap_cnt got=%0d exp=1", lap_cnt); end
    n_checks++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL lap_state got=%0d exp=1", state); end
  endtask

  task automatic test_skip();
    logic [7:0] seq [6] = '{8'd0, 8'd7, 8'd3, 8'd5, 8'd13, 8'd7};
    resync();
    skip = 1'b1;
    seen_err = 0; seen_lap = 0;
    for (int i = 0; i < 6; i++) drive(seq[i], seq[i] == 8'd3);
    n_checks++;
    if (seen_err !== 0 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL skip_ok got pulses=%0d ec=%0d exp 0 0", seen_err, err_cnt); end
    n_checks++;
    if (lap_cnt !== 16'd2) begin n_fail++; $display("FAIL skip_lap_cnt got=%0d exp=2", lap_cnt); end
    resync();
    seen_err = 0;
    for (int i = 0; i < 6; i++) drive(seq[i], 1'b0);
    n_checks++;
    if (seen_err !== 1) begin n_fail++; $display("FAIL skip_flag_err_pulses got=%0d exp=1", seen_err); end
    n_checks++;
    if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL skip_flag_err_cnt got=%0d exp=1", err_cnt); end
    n_checks++;
    if (lap_cnt !== 16'd3) begin n_fail++; $display("FAIL skip_flag_lap_cnt got=%0d exp=3", lap_cnt); end
    skip = 1'b0;
  endtask

  task automatic test_mismatch();
    resync();
    drive(8'd0, 1'b0);
    drive(8'd7, 1'b0);
    n_checks++;
    if (err_seq !== 1'b0) begin n_fail++; $display("FAIL mm_before got=%0b exp=0", err_seq); end
    drive(8'd2, 1'b0);
    n_checks++;
    if (err_seq !== 1'b1) begin n_fail++; $display("FAIL mm_pulse got=%0b exp=1", err_seq); end
    n_checks++;
    if (err_flag !== 1'b1 || err_cnt !== 8'd2) begin n_fail++; $display("FAIL mm_flag_cnt got flag=%0b ec=%0d exp 1 2", err_flag, err_cnt); end
    n_checks++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL mm_state got=%0d exp=1", state); end
    drive(8'd5, 1'b0);
    n_checks++;
    if (err_seq !== 1'b0 || err_flag !== 1'b1) begin n_fail++; $display("FAIL mm_after got seq=%0b flag=%0b exp 0 1", err_seq, err_flag); end
  endtask

  task automatic test_fault();
    clear = 1'b1;
    drive(8'd11, 1'b0);
    clear = 1'b0;
    n_checks++;
    if (err_cnt !== 8'd0 || lap_cnt !== 16'd0 || err_flag !== 1'b0 || state !== 2'd1) begin
      n_fail++; $display("FAIL clear_basic got ec=%0d lc=%0d flag=%0b st=%0d exp 0 0 0 1", err_cnt, lap_cnt, err_flag, state);
    end
    resync();
    drive(8'd0, 1'b0);
    drive(8'd7, 1'b0);
    seen_err = 0;
    for (int i = 0; i < 3; i++) drive(8'd200, 1'b0);
    n_checks++;
    if (state !== 2'd1 || err_cnt !== 8'd3) begin n_fail++; $display("FAIL fault_pre got st=%0d ec=%0d exp 1 3", state, err_cnt); end
    drive(8'd200, 1'b0);
    n_checks++;
    if (state !== 2'd2 || err_cnt !== 8'd4) begin n_fail++; $display("FAIL fault_enter got st=%0d ec=%0d exp 2 4", state, err_cnt); end
    n_checks++;
    if (seen_err !== 4) begin n_fail++; $display("FAIL fault_pulses got=%0d exp=4", seen_err); end
    drive(8'd200, 1'b0);
    n_checks++;
    if (err_seq !== 1'b0 || err_cnt !== 8'd4 || state !== 2'd2) begin
      n_fail++; $display("FAIL fault_hold got seq=%0b ec=%0d st=%0d exp 0 4 2", err_seq, err_cnt, state);
    end
    drive(8'd0, 1'b0);
    n_checks++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL fault_exit got=%0d exp=1", state); end
    drive(8'd7, 1'b0);
    n_checks++;
    if (err_seq !== 1'b0 || err_cnt !== 8'd4) begin n_fail++; $display("FAIL fault_resume got seq=%0b ec=%0d exp 0 4", err_seq, err_cnt); end
  endtask

  task automatic test_clear_sat();
    clear = 1'b1;
    drive(8'd200, 1'b0);
    clear = 1'b0;
    n_checks++;
    if (err_cnt !== 8'd0 || err_flag !== 1'b0) begin n_fail++; $display("FAIL clear_prio got ec=%0d flag=%0b exp 0 0", err_cnt, err_flag); end
    n_checks++;
    if (err_seq !== 1'b1 || state !== 2'd1) begin n_fail++; $display("FAIL clear_pulse got seq=%0b st=%0d exp 1 1", err_seq, state); end
    for (int i = 0; i < 300; i++) begin
      drive(8'd0, 1'b0);
      drive(8'd200, 1'b0);
      if (i == 253) begin
        n_checks++;
        if (err_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254 got=%0d exp=254", err_cnt); end
      end
    end
    n_checks++;
    if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_255 got=%0d exp=255", err_cnt); end
    n_checks++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL sat_state got=%0d exp=1", state); end
  endtask

  task automatic test_reset_mid();
    drive(8'd0, 1'b0);
    drive(8'd200, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({err_seq, err_flag, lap_done} !== 3'b000 || err_cnt !== 8'd0 || lap_cnt !== 16'd0 || state !== 2'd0) begin
      n_fail++; $display("FAIL async_reset got seq=%0b flag=%0b lap=%0b ec=%0d lc=%0d st=%0d exp all 0", err_seq, err_flag, lap_done, err_cnt, lap_cnt, state);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    seen_err = 0;
    drive(8'd200, 1'b0);
    drive(8'd99, 1'b0);
    n_checks++;
    if (seen_err !== 0 || state !== 2'd0) begin n_fail++; $display("FAIL post_reset_sync got pulses=%0d st=%0d exp 0 0", seen_err, state); end
    drive(8'd0, 1'b0);
    drive(8'd7, 1'b0);
    n_checks++;
    if (seen_err !== 0 || state !== 2'd1) begin n_fail++; $display("FAIL post_reset_track got pulses=%0d st=%0d exp 0 1", seen_err, state); end
    drive(8'd5, 1'b0);
    n_checks++;
    if (err_seq !== 1'b1 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL post_reset_check got seq=%0b ec=%0d exp 1 1", err_seq, err_cnt); end
  endtask

  // Sequence of scenarios, then the report.
  initial begin
    test_ref_model();
    test_reset();
    test_lap();
    test_skip();
    test_mismatch();
    test_fault();
    test_clear_sat();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_count_checker.md
FSM_COUNT_CHECKER -- requirements
Module: fsm_count_checker

Interface
REQ-001 The block SHALL have parameter ERR_W, default 8: width of the saturating error counter.
REQ-002 The block SHALL have parameter FAULT_TH, default 4: number of consecutive mismatches that forces FAULT.
REQ-003 The block SHALL have port clk, input, 1: clock, rising-edge.
REQ-004 The block SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1: same start signal that drives the counter under check.
REQ-006 The block SHALL have port skip, input, 1: same skip signal that drives the counter under check.
REQ-007 The block SHALL have port count_in, input, 8: counter value under check.
REQ-008 The block SHALL have port skip_to_five_in, input, 1: combinational flag from the counter under check.
REQ-009 The block SHALL have port check_en, input, 1: enables checking; low forces SYNC.
REQ-010 The block SHALL have port clear, input, 1: synchronous clear of err_cnt, lap_cnt and err_flag.
REQ-011 The block SHALL have output err_seq, 1: one-cycle pulse per detected mismatch.
REQ-012 The block SHALL have output err_flag, 1: sticky, set on any mismatch.
REQ-013 The block SHALL have output err_cnt, ERR_W: saturating mismatch count.
REQ-014 The block SHALL have output lap_done, 1: one-cycle pulse per legal 13->7 transition.
REQ-015 The block SHALL have output lap_cnt, 16: wrapping lap count.
REQ-016 The block SHALL have output state, 2: encoded as SYNC=0, TRACK=1, FAULT=2.

Function
REQ-017 The block SHALL define the golden next value f(c,st,sk) as follows: 0->7 if st else 0; 7->3 if sk else 1; 1->2 if sk else 3; 3->5 if sk else 2; 2->11 if sk else 5; 5->13 if sk else 11; 11->13; 13->7; any other value->0.
REQ-018 Every edge, the block SHALL register prev_count=count_in, prev_start=start and prev_skip=skip.
REQ-019 At each edge, the expected count SHALL be f(prev_count, prev_start, prev_skip).
REQ-020 The expected skip_to_five SHALL be (count_in==3 && skip), evaluated on same-edge samples.
REQ-021 A mismatch SHALL be count_in != expected count OR skip_to_five_in != expected skip_to_five, counted as at most one mismatch per cycle.
REQ-022 In SYNC, no checking SHALL occur; count_in==0 sampled with check_en=1 SHALL move the block to TRACK.
REQ-023 In TRACK, on a mismatch the block SHALL pulse err_seq in the following cycle, set err_flag, increment err_cnt and increment the consecutive-mismatch counter.
REQ-024 In TRACK, a matching cycle SHALL clear the consecutive-mismatch counter.
REQ-025 When the consecutive-mismatch counter reaches FAULT_TH, the block SHALL move to FAULT.
REQ-026 In FAULT, no checking or counting SHALL occur; count_in==0 SHALL move the block to TRACK with the consecutive-mismatch counter cleared.
REQ-027 A legal prev_count=13 to count_in=7 transition in TRACK SHALL pulse lap_done in the following cycle and increment lap_cnt, wrapping at 16'hFFFF to 0.
REQ-028 err_cnt SHALL saturate at 2^ERR_W-1.
REQ-029 check_en=0 SHALL force SYNC from any state while retaining all counters.
REQ-030 clear SHALL take priority over a same-cycle increment, leaving the counter at 0.
REQ-031 clear SHALL NOT change state.

Reset
REQ-032 rstn low SHALL asynchronously set state=SYNC and set every output, prev register and internal counter to 0.
REQ-033 Deassertion of rstn SHALL take effect at the next clk edge; reset mid-TRACK SHALL discard all history.

Structure
REQ-034 Package fsm_count_pkg SHALL hold the state enum and the sequence constants 0, 7, 1, 3, 2, 5, 11, 13.
REQ-035 The golden next-value function SHALL be one combinational sub-module, fsm_count_ref_model (inputs c, st, sk; output next), shared with testbench scoreboards.
REQ-036 All outputs SHALL be registered.

Verification
REQ-037 The bench SHALL apply reset, check_en=1, start=1, skip=0 and drive 0,7,1,3,2,5,11,13,7 -> required: no err_seq; one lap_done; lap_cnt=1; state=TRACK.
REQ-038 The bench SHALL drive skip=1 with 0,7,3,5,13,7 and skip_to_five_in=1 at 3 -> required: no error; then repeat with skip_to_five_in=0 at 3 -> required: one err_seq pulse, err_cnt=1.
REQ-039 The bench SHALL drive 7 then 2 with skip=0 -> required: err_seq pulse on the next cycle, err_flag=1, state stays TRACK.
REQ-040 The bench SHALL drive 4 consecutive illegal values in TRACK -> required: err_cnt=4, state=FAULT; then count_in=0 -> required: state=TRACK.
REQ-041 The bench SHALL assert clear in the same cycle as a mismatch -> required: err_cnt=0, err_flag=0; and force 300 mismatches with ERR_W=8 -> required: err_cnt=255.
REQ-042 The bench SHALL pull rstn low mid-TRACK -> required: all outputs 0 immediately, state=SYNC, no err_seq after release until 0 is seen.
